// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the execute-stage branch resolver: funct3 branch
// encodings, FSM state encoding and the default datapath width.
package branch_resolve_unit_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        StIdle,
        StFlush
    } state_e;

endpackage

// File: rtl/branch_resolve_unit_cond.sv
// Combinational branch-condition evaluator: funct3 plus SUB flags -> taken/illegal.
// Kept standalone so an ID-stage early resolver can reuse it.
module branch_cond_eval
    import branch_resolve_unit_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic       i_zero,
    input  logic       i_negative,
    input  logic       i_carry,
    input  logic       i_overflow,
    output logic       o_cond,
    output logic       o_illegal
);

    always_comb begin
        o_cond    = 1'b0;
        o_illegal = 1'b0;
        case (i_funct3)
            F3_BEQ:  o_cond = i_zero;
            F3_BNE:  o_cond = ~i_zero;
            F3_BLT:  o_cond = i_negative ^ i_overflow;
            F3_BGE:  o_cond = ~(i_negative ^ i_overflow);
            // Carry set means no borrow, i.e. rs1 >= rs2 unsigned.
            F3_BLTU: o_cond = ~i_carry;
            F3_BGEU: o_cond = i_carry;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/jump resolver: registered fetch redirect, wrong-path
// flush sequencing and saturating branch performance counters.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned XLEN         = XLEN_DEFAULT,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_e,
    input  logic             branch_e,
    input  logic             jal_e,
    input  logic             jalr_e,
    input  logic [2:0]       funct3_e,
    input  logic             zero_e,
    input  logic             negative_e,
    input  logic             carry_e,
    input  logic             overflow_e,
    input  logic [XLEN-1:0]  pc_e,
    input  logic [XLEN-1:0]  imm_e,
    input  logic [XLEN-1:0]  rs1_e,
    input  logic             stall_i,
    output logic             redirect_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic             flush_d_o,
    output logic             flush_e_o,
    output logic             misalign_o,
    output logic             illegal_br_o,
    output logic [CNT_W-1:0] br_count_o,
    output logic [CNT_W-1:0] taken_count_o
);

    localparam logic [2:0]       FlushLoad = 3'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};
    localparam logic [XLEN-1:0]  Bit0Mask  = ~XLEN'(1);

    logic            w_cond;
    logic            w_illegal;
    logic            w_is_br;
    logic            w_take;
    logic [XLEN-1:0] w_target;

    state_e           r_state;
    logic [2:0]       r_cnt;
    logic             r_redirect;
    logic [XLEN-1:0]  r_redirect_pc;
    logic             r_flush;
    logic             r_misalign;
    logic             r_illegal;
    logic [CNT_W-1:0] r_br_count;
    logic [CNT_W-1:0] r_taken_count;

    branch_cond_eval u_cond (
        .i_funct3   (funct3_e),
        .i_zero     (zero_e),
        .i_negative (negative_e),
        .i_carry    (carry_e),
        .i_overflow (overflow_e),
        .o_cond     (w_cond),
        .o_illegal  (w_illegal)
    );

    // A conditional branch only counts when no jump flag overrides it.
    assign w_is_br = branch_e & ~jal_e & ~jalr_e;
    assign w_take  = valid_e & (jalr_e | jal_e | (w_is_br & w_cond));

    always_comb begin
        w_target = pc_e + imm_e;
        if (jalr_e) begin
            w_target = (rs1_e + imm_e) & Bit0Mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StIdle;
            r_cnt         <= 3'd0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_flush       <= 1'b0;
            r_misalign    <= 1'b0;
            r_illegal     <= 1'b0;
            r_br_count    <= '0;
            r_taken_count <= '0;
        end else begin
            r_redirect <= 1'b0;
            r_misalign <= 1'b0;
            r_illegal  <= 1'b0;
            case (r_state)
                StIdle: begin
                    r_flush <= 1'b0;
                    if (!stall_i) begin
                        if (w_take) begin
                            if (w_target[1]) begin
                                r_misalign <= 1'b1;
                            end else begin
                                r_redirect    <= 1'b1;
                                r_redirect_pc <= w_target;
                                r_flush       <= 1'b1;
                                r_cnt         <= FlushLoad;
                                if (FlushLoad != 3'd0) begin
                                    r_state <= StFlush;
                                end
                            end
                        end
                        if (valid_e && w_is_br) begin
                            r_illegal <= w_illegal;
                            if (r_br_count != CntMax) begin
                                r_br_count <= r_br_count + 1'b1;
                            end
                            if (w_cond && r_taken_count != CntMax) begin
                                r_taken_count <= r_taken_count + 1'b1;
                            end
                        end
                    end
                end
                StFlush: begin
                    // Wrong-path EX contents are ignored; stall freezes the countdown.
                    if (!stall_i) begin
                        if (r_cnt == 3'd0) begin
                            r_flush <= 1'b0;
                            r_state <= StIdle;
                        end else begin
                            r_cnt <= r_cnt - 3'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign redirect_o    = r_redirect;
    assign redirect_pc_o = r_redirect_pc;
    assign flush_d_o     = r_flush;
    assign flush_e_o     = r_flush;
    assign misalign_o    = r_misalign;
    assign illegal_br_o  = r_illegal;
    assign br_count_o    = r_br_count;
    assign taken_count_o = r_taken_count;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (FLUSH_CYCLES=2, CNT_W=4).
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_e, branch_e, jal_e, jalr_e;
    logic [2:0]  funct3_e;
    logic        zero_e, negative_e, carry_e, overflow_e;
    logic [31:0] pc_e, imm_e, rs1_e;
    logic        stall_i;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        flush_d_o, flush_e_o, misalign_o, illegal_br_o;
    logic [3:0]  br_count_o, taken_count_o;

    int n_checks = 0;
    int n_errors = 0;

    branch_resolve_unit #(
        .XLEN         (32),
        .FLUSH_CYCLES (2),
        .CNT_W        (4)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .valid_e       (valid_e),
        .branch_e      (branch_e),
        .jal_e         (jal_e),
        .jalr_e        (jalr_e),
        .funct3_e      (funct3_e),
        .zero_e        (zero_e),
        .negative_e    (negative_e),
        .carry_e       (carry_e),
        .overflow_e    (overflow_e),
        .pc_e          (pc_e),
        .imm_e         (imm_e),
        .rs1_e         (rs1_e),
        .stall_i       (stall_i),
        .redirect_o    (redirect_o),
        .redirect_pc_o (redirect_pc_o),
        .flush_d_o     (flush_d_o),
        .flush_e_o     (flush_e_o),
        .misalign_o    (misalign_o),
        .illegal_br_o  (illegal_br_o),
        .br_count_o    (br_count_o),
        .taken_count_o (taken_count_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        valid_e = 0; branch_e = 0; jal_e = 0; jalr_e = 0; funct3_e = 3'b000;
        zero_e = 0; negative_e = 0; carry_e = 0; overflow_e = 0;
        pc_e = 0; imm_e = 0; rs1_e = 0; stall_i = 0;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic set_br(input logic [2:0] f3, input logic z, input logic n, input logic c,
                          input logic v, input logic [31:0] pc, input logic [31:0] imm);
        clear_in();
        valid_e = 1; branch_e = 1; funct3_e = f3;
        zero_e = z; negative_e = n; carry_e = c; overflow_e = v;
        pc_e = pc; imm_e = imm;
    endtask

    task automatic check_flush(input string tag, input logic exp);
        check_eq({tag, "_fd"}, 32'(flush_d_o), 32'(exp));
        check_eq({tag, "_fe"}, 32'(flush_e_o), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        check_eq("rst_redir", 32'(redirect_o), 0);
        check_eq("rst_pc", redirect_pc_o, 0);
        check_flush("rst", 0);
        check_eq("rst_mis", 32'(misalign_o), 0);
        check_eq("rst_ill", 32'(illegal_br_o), 0);
        check_eq("rst_br", 32'(br_count_o), 0);
        check_eq("rst_tk", 32'(taken_count_o), 0);

        // BEQ taken: redirect next cycle, flush exactly two cycles.
        set_br(3'b000, 1, 0, 0, 0, 32'h100, 32'h20);
        tick();
        check_eq("beq_redir", 32'(redirect_o), 1);
        check_eq("beq_pc", redirect_pc_o, 32'h120);
        check_flush("beq_c1", 1);
        check_eq("beq_tk", 32'(taken_count_o), 1);
        check_eq("beq_br", 32'(br_count_o), 1);
        clear_in();
        tick();
        check_eq("beq_redir_once", 32'(redirect_o), 0);
        check_flush("beq_c2", 1);
        tick();
        check_flush("beq_c3", 0);
        check_eq("beq_pc_hold", redirect_pc_o, 32'h120);

        // Not-taken conditions.
        set_br(3'b110, 0, 0, 1, 0, 32'h200, 32'h40);
        tick();
        check_eq("bltu_redir", 32'(redirect_o), 0);
        check_eq("bltu_br", 32'(br_count_o), 2);
        check_eq("bltu_tk", 32'(taken_count_o), 1);
        set_br(3'b100, 0, 1, 0, 1, 32'h200, 32'h40);
        tick();
        check_eq("blt_redir", 32'(redirect_o), 0);
        set_br(3'b101, 0, 1, 0, 0, 32'h200, 32'h40);
        tick();
        check_eq("bge_redir", 32'(redirect_o), 0);
        check_flush("bge", 0);
        check_eq("bge_br", 32'(br_count_o), 4);
        check_eq("bge_tk", 32'(taken_count_o), 1);

        // JALR misaligned then aligned.
        clear_in(); valid_e = 1; jalr_e = 1; rs1_e = 32'h1003; imm_e = 32'h4; pc_e = 32'h80;
        tick();
        check_eq("jalr_mis", 32'(misalign_o), 1);
        check_eq("jalr_mis_redir", 32'(redirect_o), 0);
        check_flush("jalr_mis", 0);
        check_eq("jalr_mis_pc", redirect_pc_o, 32'h120);
        clear_in();
        tick();
        check_eq("jalr_mis_pulse", 32'(misalign_o), 0);
        valid_e = 1; jalr_e = 1; rs1_e = 32'h1001; imm_e = 32'h4; pc_e = 32'h80;
        tick();
        check_eq("jalr_redir", 32'(redirect_o), 1);
        check_eq("jalr_pc", redirect_pc_o, 32'h1004);
        check_eq("jalr_br", 32'(br_count_o), 4);
        clear_in();
        tick();
        tick();

        // Taken branches arriving during the flush window are ignored.
        do_reset();
        set_br(3'b001, 0, 0, 0, 0, 32'h200, 32'h40);
        tick();
        check_eq("win_redir", 32'(redirect_o), 1);
        check_eq("win_pc", redirect_pc_o, 32'h240);
        set_br(3'b001, 0, 0, 0, 0, 32'h300, 32'h10);
        tick();
        check_eq("win2_redir", 32'(redirect_o), 0);
        check_flush("win2", 1);
        tick();
        check_eq("win3_redir", 32'(redirect_o), 0);
        check_flush("win3", 0);
        check_eq("win_pc_hold", redirect_pc_o, 32'h240);
        check_eq("win_br", 32'(br_count_o), 1);
        check_eq("win_tk", 32'(taken_count_o), 1);

        // Stall held three cycles in FLUSH stretches the flush by three.
        clear_in(); valid_e = 1; jal_e = 1; pc_e = 32'h400; imm_e = 32'h8;
        tick();
        check_eq("jal_redir", 32'(redirect_o), 1);
        check_eq("jal_pc", redirect_pc_o, 32'h408);
        clear_in(); stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_flush("stall_hold", 1);
            check_eq("stall_redir", 32'(redirect_o), 0);
        end
        stall_i = 0;
        tick();
        check_flush("stall_c5", 1);
        tick();
        check_flush("stall_c6", 0);

        // Stall in IDLE defers the decision until release.
        set_br(3'b111, 0, 0, 1, 0, 32'h500, 32'h10);
        stall_i = 1;
        tick();
        check_eq("idle_stall_redir", 32'(redirect_o), 0);
        check_eq("idle_stall_br", 32'(br_count_o), 1);
        stall_i = 0;
        tick();
        check_eq("idle_rel_redir", 32'(redirect_o), 1);
        check_eq("idle_rel_pc", redirect_pc_o, 32'h510);
        check_eq("idle_rel_tk", 32'(taken_count_o), 2);

        // Reset during the first flush cycle aborts the flush.
        rst = 1; clear_in();
        tick();
        rst = 0;
        check_flush("midrst", 0);
        check_eq("midrst_redir", 32'(redirect_o), 0);
        check_eq("midrst_pc", redirect_pc_o, 0);
        check_eq("midrst_br", 32'(br_count_o), 0);
        tick();
        check_flush("midrst_idle", 0);
        set_br(3'b000, 1, 0, 0, 0, 32'h600, 32'h4);
        tick();
        check_eq("midrst_new_redir", 32'(redirect_o), 1);
        check_eq("midrst_new_pc", redirect_pc_o, 32'h604);
        clear_in();
        tick();
        tick();

        // Illegal funct3: pulse, not taken, still counted.
        set_br(3'b010, 1, 0, 1, 0, 32'h700, 32'h8);
        tick();
        check_eq("ill_pulse", 32'(illegal_br_o), 1);
        check_eq("ill_redir", 32'(redirect_o), 0);
        check_eq("ill_br", 32'(br_count_o), 2);
        check_eq("ill_tk", 32'(taken_count_o), 1);
        clear_in();
        tick();
        check_eq("ill_pulse_end", 32'(illegal_br_o), 0);

        // Saturation at 15 with CNT_W=4.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            set_br(3'b000, 1, 0, 0, 0, 32'h800, 32'h10);
            tick();
            clear_in();
            tick();
            tick();
        end
        check_eq("sat_br", 32'(br_count_o), 15);
        check_eq("sat_tk", 32'(taken_count_o), 15);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
